// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 multiplexer.
// Latency: none (package only).
// Backpressure: not applicable.
package mux_pkg;

    // Select-mode encodings for the rr_mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, used to size the select register.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Circular-priority picker: first channel with in_valid set, searching upward from start.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own ready logic.
//
// Ports:
//   in_valid  per-channel request vector
//   start     channel that has the highest priority this cycle
//   grant     chosen channel (equals start when nothing is valid)
//   any       at least one channel is valid
module mux_rr_pick
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    in_valid,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] grant,
    output logic            any
);

    // Walk from the farthest channel back to start so the last hit
    // is the closest one in circular order.
    always_comb begin
        grant = start;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[(int'(start) + k) % N]) begin
                grant = SELW'((int'(start) + k) % N);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// Registered N:1 stream multiplexer with valid/ready handshakes and a registered select.
// Latency: 1 cycle from input transfer to out_valid; one word per cycle at full rate.
// Backpressure: in_ready drops on every channel while out_valid & !out_ready.
//
// Optional build macro MUX_RR_EN: adds round-robin selection while rr_mode=1.
//
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   in_data/in_valid/in_ready   N producer streams, channel i in in_data[i*W +: W]
//   sel, sel_load         new select value and its load strobe
//   rr_mode               1 = round-robin (only with MUX_RR_EN)
//   out_data/out_valid/out_ready  registered consumer stream
//   sel_err               sticky flag: sel_load seen with sel >= N
module mux_n_to_1_reg
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 1,
    localparam int SELW = clog2(N)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    input  logic            sel_load,
    input  logic            rr_mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sel_err
);

    // One extra bit so the range check also works when N is a power of 2.
    localparam logic [SELW:0] N_LIM = (SELW + 1)'(N);

    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic            can_load;
    logic            transfer;

`ifdef MUX_RR_EN
    logic [SELW-1:0] rr_grant;
    logic            rr_any;
    logic            rr_active;
    logic [SELW-1:0] grant_next;

    mux_rr_pick #(
        .N (N)
    ) u_rr_pick (
        .in_valid (in_valid),
        .start    (sel_q),
        .grant    (rr_grant),
        .any      (rr_any)
    );

    assign rr_active  = (rr_mode == MODE_RR);
    assign grant      = rr_active ? rr_grant : sel_q;
    assign grant_vld  = rr_active ? rr_any : in_valid[grant];
    assign grant_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
`else
    logic unused_rr_mode;

    assign unused_rr_mode = rr_mode;
    assign grant          = sel_q;
    assign grant_vld      = in_valid[grant];
`endif

    // The output register can take a word when empty or being drained now.
    assign can_load = !out_valid || out_ready;
    assign transfer = reset_n && grant_vld && can_load;

    always_comb begin
        in_ready = '0;
        if (reset_n && can_load) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (transfer) begin
                out_data  <= in_data[int'(grant) * W +: W];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // An explicit load overrides the round-robin advance; an
            // out-of-range value leaves sel_q alone and latches the error.
            if (sel_load) begin
                if ({1'b0, sel} < N_LIM) begin
                    sel_q <= sel;
                end else begin
                    sel_err <= 1'b1;
                end
            end
`ifdef MUX_RR_EN
            else if (rr_active && transfer) begin
                sel_q <= grant_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
module tb_mux_n_to_1_reg;

`ifdef MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        sel_load;
    logic        rr_mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        sel_load3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        sel_err3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the output register should hold, plus select and error.
    logic [7:0] q[$];
    int         m_sel;
    bit         m_valid;
    bit         m_err;
    bit         just_reset;

    mux_n_to_1_reg #(.N(4), .W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .sel_load  (sel_load),
        .rr_mode   (rr_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    mux_n_to_1_reg #(.N(3), .W(8)) dut3 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .sel_load  (sel_load3),
        .rr_mode   (1'b0),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .sel_err   (sel_err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    // Reference model for one cycle; inputs are already applied for this cycle.
    task automatic step();
        int         g;
        bit         found;
        bit         can;
        bit         xfer;
        logic [3:0] exp_rdy;
        #2;
        if (!reset_n) begin
            chk("in_ready_in_reset", in_ready, 0);
            m_sel      = 0;
            m_valid    = 0;
            m_err      = 0;
            just_reset = 1;
            q.delete();
        end else begin
            if (just_reset) begin
                chk("out_data_after_reset", out_data, 0);
                just_reset = 0;
            end
            chk("sel_err", sel_err, m_err);
            g     = m_sel;
            found = in_valid[m_sel];
            if (RR && rr_mode) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && in_valid[(m_sel + k) % 4]) begin
                        g     = (m_sel + k) % 4;
                        found = 1;
                    end
                end
            end
            can     = !m_valid || out_ready;
            exp_rdy = can ? (4'b0001 << g) : 4'b0000;
            chk("in_ready", in_ready, exp_rdy);
            xfer = found && can;
            if (xfer) q.push_back(in_data[g*8 +: 8]);
            m_valid = xfer ? 1'b1 : (out_ready ? 1'b0 : m_valid);
            if (sel_load) begin
                if (sel < 4) m_sel = sel;
                else m_err = 1;
            end else if (RR && rr_mode && xfer) begin
                m_sel = (g + 1) % 4;
            end
        end
    endtask

    // Monitor: every word presented must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (reset_n) begin
                chk("out_valid", out_valid, (q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    chk("out_data", out_data, q[0]);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        reset_n = 0; in_data = 0; in_valid = 0; sel = 0; sel_load = 0;
        rr_mode = 0; out_ready = 1;
        in_data3 = 0; in_valid3 = 0; sel3 = 0; sel_load3 = 0;
        m_sel = 0; m_valid = 0; m_err = 0; just_reset = 0;

        for (int i = 0; i < 2; i++) begin next_cycle(); step(); end
        next_cycle(); reset_n = 1; step();

        // Select ch2 and send A5; the load only applies from the next cycle.
        next_cycle(); sel = 2; sel_load = 1; in_valid = 4'b0100;
        in_data = 32'h00A5_0000; out_ready = 1; step();
        next_cycle(); sel_load = 0; step();
        chk("first_grant_ch2", in_ready, 4'b0100);
        // Three cycles of backpressure with the next word waiting.
        next_cycle(); in_data = 32'h00B6_0000; out_ready = 0; step();
        next_cycle(); step();
        next_cycle(); step();
        next_cycle(); out_ready = 1; step();
        next_cycle(); in_valid = 0; step();

        // Load sel=3 in the same cycle as a ch1 transfer.
        next_cycle(); sel = 1; sel_load = 1; step();
        next_cycle(); sel = 3; sel_load = 1; in_valid = 4'b0010;
        in_data = 32'hD300_C100; step();
        next_cycle(); sel_load = 0; in_valid = 4'b1000; step();
        next_cycle(); in_valid = 0; step();

        // Three-channel instance: out-of-range select.
        next_cycle(); sel3 = 1; sel_load3 = 1; step();
        next_cycle(); sel3 = 3; sel_load3 = 1; step();
        chk("n3_ready_sel1", in_ready3, 3'b010);
        next_cycle(); sel_load3 = 0; step();
        chk("n3_sel_err_set", sel_err3, 1);
        chk("n3_sel_q_kept", in_ready3, 3'b010);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); step();
            chk("n3_sel_err_sticky", sel_err3, 1);
        end

        // Round-robin order with every channel valid, then a sparse pattern.
        next_cycle(); sel = 0; sel_load = 1; step();
        next_cycle(); sel_load = 0; rr_mode = 1; in_valid = 4'b1111;
        in_data = 32'h1312_1110; step();
        for (int i = 0; i < 4; i++) begin next_cycle(); step(); end
        next_cycle(); in_valid = 4'b1010; in_data = 32'hA3A2_A1A0; step();
        for (int i = 0; i < 2; i++) begin next_cycle(); step(); end
        next_cycle(); rr_mode = 0; in_valid = 0; step();

        // Reset mid-stream with a word held.
        next_cycle(); sel = 1; sel_load = 1; step();
        next_cycle(); sel_load = 0; in_valid = 4'b0010; in_data = 32'h0000_7700; step();
        next_cycle(); out_ready = 0; reset_n = 0; step();
        next_cycle(); reset_n = 1; out_ready = 1; in_valid = 0; step();
        chk("out_valid_after_reset", out_valid, 0);
        chk("sel_q_after_reset", in_ready, 4'b0001);
        chk("n3_sel_err_cleared", sel_err3, 0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            reset_n   = ($urandom_range(0, 199) != 0);
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            sel_load  = ($urandom_range(0, 7) == 0);
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            step();
        end

        // Drain.
        next_cycle(); reset_n = 1; in_valid = 0; sel_load = 0; out_ready = 1; step();
        for (int i = 0; i < 3; i++) begin next_cycle(); step(); end
        chk("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
